fetch_pc_unit: RTL and testbench

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

---
 rtl/fetch_pc_pkg.sv | 15 +
 rtl/fetch_pc_unit_ras_stack.sv | 48 ++++
 rtl/fetch_pc_unit.sv | 121 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_pkg.sv
// Shared constants and next-PC selector encoding for the fetch PC unit.
package fetch_pc_pkg;

    localparam int IMM19_W = 19;
    localparam int IMM26_W = 26;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        NPC_SEQ,
        NPC_BR,
        NPC_RET,
        NPC_HOLD
    } npc_sel_e;

endpackage

// File: rtl/fetch_pc_unit_ras_stack.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest entry,
// and a call+return pair in the same cycle replaces the top entry in place.
module ras_stack #(
    parameter int ADDR_W    = 64,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_addr,
    output logic [ADDR_W-1:0] top_addr,
    output logic              empty,
    output logic              full
);

    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] entries [RAS_DEPTH];
    logic [PTR_W-1:0]  top_ptr;
    logic [PTR_W-1:0]  next_ptr;
    logic [PTR_W:0]    count;

    assign next_ptr = top_ptr + PTR_W'(1);
    assign top_addr = entries[top_ptr];
    assign empty    = (count == '0);
    assign full     = (count == (PTR_W+1)'(RAS_DEPTH));

    // Pointer arithmetic wraps naturally because RAS_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            top_ptr <= '0;
            count   <= '0;
        end else if (push && pop && !empty) begin
            entries[top_ptr] <= push_addr;
        end else if (push) begin
            top_ptr           <= next_ptr;
            entries[next_ptr] <= push_addr;
            if (!full) begin
                count <= count + (PTR_W+1)'(1);
            end
        end else if (pop && !empty) begin
            top_ptr <= top_ptr - PTR_W'(1);
            count   <= count - (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch/decode PC pair with one-bubble branch and return redirect.
// Define FETCH_PC_RAS_EN to build in the return-address stack.
module fetch_pc_unit
    import fetch_pc_pkg::*;
#(
    parameter int               ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               stall,
    input  logic               br_taken,
    input  logic               uncond_br,
    input  logic               is_call,
    input  logic               is_ret,
    input  logic [ADDR_W-1:0]  reg_target,
    output logic [ADDR_W-1:0]  pc_fetch,
    output logic [ADDR_W-1:0]  pc_dec,
    output logic               dec_valid,
    output logic               redirect,
    output logic               ras_empty,
    output logic               ras_full
);

    localparam int OFF_W = IMM26_W + 2;
    localparam int EXT_W = (ADDR_W > OFF_W) ? ADDR_W : OFF_W;

    npc_sel_e           npc_sel;
    logic               qual_br;
    logic               qual_ret;
    logic signed [OFF_W-1:0] br_off_raw;
    logic [EXT_W-1:0]   br_off_ext;
    logic [ADDR_W-1:0]  br_target;
    logic [ADDR_W-1:0]  ret_addr;
    logic [ADDR_W-1:0]  ret_target;
    logic [ADDR_W-1:0]  pc_next;
    logic [5:0]         instr_unused;

    assign qual_br      = dec_valid && br_taken;
    assign qual_ret     = dec_valid && is_ret;
    assign instr_unused = instruction[INSTR_W-1:IMM26_W];

    // Both immediates are built pre-shifted at 28 bits, then sign-extended to the PC width.
    always_comb begin
        br_off_raw = uncond_br ? {instruction[IMM26_W-1:0], 2'b00}
                               : {{(IMM26_W-IMM19_W){instruction[IMM19_W+4]}},
                                  instruction[IMM19_W+4:5], 2'b00};
        br_off_ext = EXT_W'(br_off_raw);
    end

    assign br_target = pc_dec + br_off_ext[ADDR_W-1:0];
    assign ret_addr  = pc_dec + ADDR_W'(4);

`ifdef FETCH_PC_RAS_EN
    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_top;

    assign ras_push = reset && !stall && qual_br && is_call;
    assign ras_pop  = reset && !stall && qual_ret;

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_addr (ret_addr),
        .top_addr  (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign ret_target = ras_empty ? reg_target : ras_top;
`else
    logic ras_unused;

    assign ras_unused = is_call ^ (|ret_addr);
    assign ret_target = reg_target;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
`endif

    always_comb begin
        npc_sel  = NPC_SEQ;
        pc_next  = pc_fetch + ADDR_W'(4);
        redirect = 1'b0;
        if (stall) begin
            npc_sel = NPC_HOLD;
        end else if (qual_ret) begin
            npc_sel = NPC_RET;
        end else if (qual_br) begin
            npc_sel = NPC_BR;
        end
        case (npc_sel)
            NPC_HOLD: pc_next = pc_fetch;
            NPC_RET:  pc_next = ret_target;
            NPC_BR:   pc_next = br_target;
            default:  pc_next = pc_fetch + ADDR_W'(4);
        endcase
        redirect = reset && ((npc_sel == NPC_RET) || (npc_sel == NPC_BR));
    end

    // The slot fetched alongside a redirect is wrong-path, so it enters decode invalid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_fetch  <= RESET_PC;
            pc_dec    <= RESET_PC;
            dec_valid <= 1'b0;
        end else if (!stall) begin
            pc_fetch  <= pc_next;
            pc_dec    <= pc_fetch;
            dec_valid <= !redirect;
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed vector bench for fetch_pc_unit (16-bit PCs, RESET_PC 0x100, RAS depth 4).
module tb_fetch_pc_unit;

    localparam logic [31:0] NOP     = 32'hD503201F;
    localparam logic [31:0] BR_M2   = 32'h54FFFFC0;
    localparam logic [31:0] BR_P4   = 32'h54000080;
    localparam logic [31:0] B26_P16 = 32'h14000010;
    localparam logic [31:0] B26_M2  = 32'h17FFFFFE;

    typedef struct {
        string       name;
        logic        rst;
        logic        stall;
        logic        br_taken;
        logic        uncond_br;
        logic        is_call;
        logic        is_ret;
        logic [15:0] reg_target;
        logic [31:0] instruction;
        logic        exp_redirect;
        logic [15:0] exp_pc_fetch;
        logic [15:0] exp_pc_dec;
        logic        exp_dec_valid;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        stall;
    logic        br_taken;
    logic        uncond_br;
    logic        is_call;
    logic        is_ret;
    logic [15:0] reg_target;
    logic [15:0] pc_fetch;
    logic [15:0] pc_dec;
    logic        dec_valid;
    logic        redirect;
    logic        ras_empty;
    logic        ras_full;

    int n_compared   = 0;
    int n_mismatched = 0;

    vec_t vecs[$];

    fetch_pc_unit #(
        .ADDR_W    (16),
        .RESET_PC  (16'h0100),
        .RAS_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .stall       (stall),
        .br_taken    (br_taken),
        .uncond_br   (uncond_br),
        .is_call     (is_call),
        .is_ret      (is_ret),
        .reg_target  (reg_target),
        .pc_fetch    (pc_fetch),
        .pc_dec      (pc_dec),
        .dec_valid   (dec_valid),
        .redirect    (redirect),
        .ras_empty   (ras_empty),
        .ras_full    (ras_full)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset       = v.rst;
        stall       = v.stall;
        br_taken    = v.br_taken;
        uncond_br   = v.uncond_br;
        is_call     = v.is_call;
        is_ret      = v.is_ret;
        reg_target  = v.reg_target;
        instruction = v.instruction;
    endtask

    // Drive one cycle's inputs, check the combinational redirect, then the registered state.
    task automatic runVector(input vec_t v);
        applyStimulus(v);
        #2;
        checkOutput({v.name, " redirect"}, 64'(redirect), 64'(v.exp_redirect));
        @(posedge clk);
        #1;
        checkOutput({v.name, " pc_fetch"}, 64'(pc_fetch), 64'(v.exp_pc_fetch));
        checkOutput({v.name, " pc_dec"}, 64'(pc_dec), 64'(v.exp_pc_dec));
        checkOutput({v.name, " dec_valid"}, 64'(dec_valid), 64'(v.exp_dec_valid));
    endtask

    function automatic vec_t mkVec(input string name, input logic stl, input logic br, input logic unc,
                                   input logic call, input logic ret, input logic [15:0] rt,
                                   input logic [31:0] ins, input logic red, input logic [15:0] pf,
                                   input logic [15:0] pd, input logic dv);
        vec_t v;
        v = '{name, 1'b1, stl, br, unc, call, ret, rt, ins, red, pf, pd, dv};
        return v;
    endfunction

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] cur_pf;
        logic [15:0] cur_pd;
        vec_t v;

        vecs.push_back(mkVec("rel0",     0, 0, 0, 0, 0, 16'h0000, NOP,     0, 16'h0104, 16'h0100, 1));
        vecs.push_back(mkVec("rel1",     0, 0, 0, 0, 0, 16'h0000, NOP,     0, 16'h0108, 16'h0104, 1));
        vecs.push_back(mkVec("ret200",   0, 0, 0, 0, 1, 16'h0200, NOP,     1, 16'h0200, 16'h0108, 0));
        vecs.push_back(mkVec("squashed", 0, 1, 0, 0, 1, 16'h0500, BR_M2,   0, 16'h0204, 16'h0200, 1));
        vecs.push_back(mkVec("br_m2",    0, 1, 0, 0, 0, 16'h0000, BR_M2,   1, 16'h01F8, 16'h0204, 0));
        vecs.push_back(mkVec("after_br", 0, 0, 0, 0, 0, 16'h0000, NOP,     0, 16'h01FC, 16'h01F8, 1));
        vecs.push_back(mkVec("stall0",   1, 1, 0, 0, 0, 16'h0000, BR_P4,   0, 16'h01FC, 16'h01F8, 1));
        vecs.push_back(mkVec("stall1",   1, 1, 0, 0, 0, 16'h0000, BR_P4,   0, 16'h01FC, 16'h01F8, 1));
        vecs.push_back(mkVec("stall2",   1, 1, 0, 0, 0, 16'h0000, BR_P4,   0, 16'h01FC, 16'h01F8, 1));
        vecs.push_back(mkVec("unstall",  0, 1, 0, 0, 0, 16'h0000, BR_P4,   1, 16'h0208, 16'h01FC, 0));
        vecs.push_back(mkVec("idle_a",   0, 0, 0, 0, 0, 16'h0000, NOP,     0, 16'h020C, 16'h0208, 1));
        vecs.push_back(mkVec("b26_p16",  0, 1, 1, 0, 0, 16'h0000, B26_P16, 1, 16'h0248, 16'h020C, 0));
        vecs.push_back(mkVec("idle_b",   0, 0, 0, 0, 0, 16'h0000, NOP,     0, 16'h024C, 16'h0248, 1));
        vecs.push_back(mkVec("ret0",     0, 0, 0, 0, 1, 16'h0000, NOP,     1, 16'h0000, 16'h024C, 0));
        vecs.push_back(mkVec("idle_c",   0, 0, 0, 0, 0, 16'h0000, NOP,     0, 16'h0004, 16'h0000, 1));
        vecs.push_back(mkVec("idle_d",   0, 0, 0, 0, 0, 16'h0000, NOP,     0, 16'h0008, 16'h0004, 1));
        vecs.push_back(mkVec("b26_m2",   0, 1, 1, 0, 0, 16'h0000, B26_M2,  1, 16'hFFFC, 16'h0008, 0));
        vecs.push_back(mkVec("wrap",     0, 0, 0, 0, 0, 16'h0000, NOP,     0, 16'h0000, 16'hFFFC, 1));
        vecs.push_back(mkVec("retABC0",  0, 0, 0, 0, 1, 16'hABC0, NOP,     1, 16'hABC0, 16'h0000, 0));
        vecs.push_back(mkVec("idle_e",   0, 0, 0, 0, 0, 16'h0000, NOP,     0, 16'hABC4, 16'hABC0, 1));
        v = mkVec("rst_mid",  1, 1, 0, 0, 1, 16'h0900, BR_M2,   0, 16'h0100, 16'h0100, 0);
        v.rst = 1'b0;
        vecs.push_back(v);
        vecs.push_back(mkVec("rel2",     0, 0, 0, 0, 0, 16'h0000, NOP,     0, 16'h0104, 16'h0100, 1));

        reset       = 1'b0;
        stall       = 1'b0;
        br_taken    = 1'b1;
        uncond_br   = 1'b0;
        is_call     = 1'b0;
        is_ret      = 1'b1;
        reg_target  = 16'h0900;
        instruction = NOP;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset pc_fetch", 64'(pc_fetch), 64'h0100);
        checkOutput("reset pc_dec", 64'(pc_dec), 64'h0100);
        checkOutput("reset dec_valid", 64'(dec_valid), 64'h0);
        checkOutput("reset redirect", 64'(redirect), 64'h0);
        checkOutput("reset ras_empty", 64'(ras_empty), 64'h1);
        checkOutput("reset ras_full", 64'(ras_full), 64'h0);

        foreach (vecs[i]) begin
            runVector(vecs[i]);
        end

`ifdef FETCH_PC_RAS_EN
        cur_pf = 16'h0104;
        cur_pd = 16'h0100;
        for (int k = 0; k < 5; k++) begin
            v = mkVec($sformatf("call%0d", k), 0, 1, 0, 1, 0, 16'h0000, BR_P4, 1,
                      cur_pd + 16'h0010, cur_pf, 0);
            runVector(v);
            cur_pd = cur_pf;
            cur_pf = v.exp_pc_fetch;
            v = mkVec($sformatf("call%0d_idle", k), 0, 0, 0, 0, 0, 16'h0000, NOP, 0,
                      cur_pf + 16'h0004, cur_pf, 1);
            runVector(v);
            cur_pd = cur_pf;
            cur_pf = cur_pf + 16'h0004;
        end
        checkOutput("ras_full after 5 calls", 64'(ras_full), 64'h1);
        checkOutput("ras_empty after 5 calls", 64'(ras_empty), 64'h0);
        for (int j = 0; j < 5; j++) begin
            logic [15:0] tgt;
            tgt = (j < 4) ? 16'(16'h0144 - 16'(j * 16)) : 16'h777C;
            v = mkVec($sformatf("ret%0d", j), 0, 0, 0, 0, 1, 16'h777C, NOP, 1, tgt, cur_pf, 0);
            runVector(v);
            cur_pf = tgt;
            v = mkVec($sformatf("ret%0d_idle", j), 0, 0, 0, 0, 0, 16'h0000, NOP, 0,
                      cur_pf + 16'h0004, cur_pf, 1);
            runVector(v);
            cur_pf = cur_pf + 16'h0004;
            if (j == 3) begin
                checkOutput("ras_empty after 4 returns", 64'(ras_empty), 64'h1);
                checkOutput("ras_full after 4 returns", 64'(ras_full), 64'h0);
            end
        end
`else
        cur_pf = 16'h0104;
        cur_pd = 16'h0100;
        checkOutput("ras_empty without stack", 64'(ras_empty), 64'h1);
        checkOutput("ras_full without stack", 64'(ras_full), 64'h0);
        v = mkVec("call_nostack", 0, 1, 0, 1, 0, 16'h0000, BR_P4, 1, cur_pd + 16'h0010, cur_pf, 0);
        runVector(v);
        checkOutput("ras_empty after call", 64'(ras_empty), 64'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
